traffic_light_timer: RTL
========================

# traffic_light_timer

Time base for the traffic light controller: divides `clk` down to one-second ticks and counts elapsed seconds since the last restart. It drives the controller's `one_sec_timer` and `five_sec_timer` inputs and consumes its `rst_count` request. Together the two blocks form the complete timed light sequencer: the controller sequences the lights, and this block supplies the phase durations.

## Interface
Parameters:
- `CLKS_PER_SEC`, default 50_000_000: clk cycles per second tick. Legal range ≥ 2.
- `SHORT_SEC`, default 1: seconds until `one_sec_timer` asserts. Legal range ≥ 1.
- `LONG_SEC`, default 5: seconds until `five_sec_timer` asserts. Must satisfy SHORT_SEC < LONG_SEC < 2**SEC_W.
- `SEC_W`, default 4: width of the seconds counter.

Ports:
- `clk` input 1: single clock; all logic is in this domain.
- `reset_n` input 1: asynchronous, active-low reset.
- `rst_count` input 1: synchronous restart request from the controller. Sampled at `clk` posedge.
- `one_sec_timer` output 1: level flag; elapsed time ≥ SHORT_SEC.
- `five_sec_timer` output 1: level flag; elapsed time ≥ LONG_SEC.
- `hold` input 1: present only with `TL_TIMER_HOLD_EN`; freezes timekeeping.

## Operation
- Internal registers:
  - `pre_cnt`, width $clog2(CLKS_PER_SEC): prescaler.
  - `sec_cnt`, width SEC_W: seconds counter.
  - Two registered output flags.
- Prescaler behaviour:
  - Counts 0..CLKS_PER_SEC-1, then wraps to 0.
  - `tick` = (pre_cnt == CLKS_PER_SEC-1) and not frozen.
- Seconds counter behaviour:
  - Increments on `tick`.
  - Saturates at LONG_SEC; no wrap. The prescaler continues wrapping while saturated.
- Flags are registered:
  - `one_sec_timer` <= (next sec_cnt ≥ SHORT_SEC).
  - `five_sec_timer` <= (next sec_cnt ≥ LONG_SEC).
  - Both flags are levels. They stay high until restart, so a controller that samples late never misses them.
- `rst_count` = 1 at an edge:
  - `pre_cnt`, `sec_cnt` and both flags go to 0 at that edge.
  - It has priority over a coincident `tick` and over `hold`.
- `rst_count` held high continuously: counters stay at 0 and flags never assert.
- Reset (`reset_n` low, any time, including mid-count):
  - All registers clear immediately, without waiting for a clock.
  - Reset values: `one_sec_timer`=0, `five_sec_timer`=0, `pre_cnt`=0, `sec_cnt`=0.
  - Counting resumes at the first posedge after `reset_n` rises.
- Out-of-range parameters: rejected at elaboration via `$error`.

## Timing
- Let `rst_count` be sampled high at edge k (or reset released before edge k).
  - `one_sec_timer` goes high after edge k + SHORT_SEC·CLKS_PER_SEC.
  - `five_sec_timer` goes high after edge k + LONG_SEC·CLKS_PER_SEC.
  - Both rise exactly at a tick edge and never earlier.
- Flags fall at the edge that samples `rst_count` = 1. They are low from the next cycle.
- Flag outputs are driven directly from flops, with no combinational path from `rst_count`. This avoids a combinational loop with the controller, whose `rst_count` is combinational from the timer flags.
- Closed-loop behaviour with the controller: a green phase lasts LONG_SEC·CLKS_PER_SEC + 1 cycles. The extra cycle is the state-register update.

## Configuration
- `TL_TIMER_HOLD_EN` defined:
  - The `hold` port exists.
  - While `hold`=1 (and `rst_count`=0), `pre_cnt`, `sec_cnt` and the flags keep their values.
  - Counting resumes from the frozen value when `hold` deasserts.
- `TL_TIMER_HOLD_EN` not defined:
  - The `hold` port is absent.
  - Timekeeping always runs.
  - Logic is identical to `hold` tied to 0.

## Test plan
All scenarios use CLKS_PER_SEC=10, SHORT_SEC=1, LONG_SEC=5.
1. Release reset, keep `rst_count`=0 -> `one_sec_timer` rises after edge 10, `five_sec_timer` after edge 50, and both stay high through edge 200 (saturation, no wrap).
2. Pulse `rst_count` for one cycle at edge 23 -> both flags are 0 from edge 23. `one_sec_timer` rises after edge 33 and `five_sec_timer` after edge 73.
3. Assert `rst_count` coincident with a tick (edge 10, 20, …) and hold it high for 100 cycles -> `sec_cnt` stays 0 and the flags stay 0 throughout.
4. Drop `reset_n` asynchronously mid-cycle at cycle 37 -> flags and counters are 0 immediately. After release, `one_sec_timer` rises 10 edges later.
5. With `TL_TIMER_HOLD_EN`: hold=1 for cycles 15–34 -> `one_sec_timer` rises after edge 10 (unchanged) and `five_sec_timer` after edge 70. Also assert `hold` and `rst_count` together -> the restart wins.
6. Closed loop with the controller -> S0, S2, S4 and S6 each last 51 cycles, S1, S3, S5 and S7 each last 11 cycles, and IDLE lasts 1 cycle.

Source files
------------

// File: rtl/traffic_light_timer.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_timer
// Purpose  : Time base for the traffic light controller. Divides clk down to
//            one-second ticks and counts whole seconds since the last restart.
//            The controller samples the two level flags and pulses rst_count
//            to start the next phase.
// Ports    : clk            - single clock, all logic in this domain
//            reset_n        - asynchronous active-low reset
//            rst_count      - synchronous restart request (sampled at posedge)
//            hold           - freeze timekeeping (only with TL_TIMER_HOLD_EN)
//            one_sec_timer  - level: elapsed time >= SHORT_SEC seconds
//            five_sec_timer - level: elapsed time >= LONG_SEC seconds
// Options  : TL_TIMER_HOLD_EN - adds the hold input. Without it, timekeeping
//            always runs (identical to hold tied low).
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_timer #(
    parameter int CLKS_PER_SEC = 50_000_000,
    parameter int SHORT_SEC    = 1,
    parameter int LONG_SEC     = 5,
    parameter int SEC_W        = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rst_count,
`ifdef TL_TIMER_HOLD_EN
    input  logic hold,
`endif
    output logic one_sec_timer,
    output logic five_sec_timer
);

    // Prescaler width; guarded so an illegal CLKS_PER_SEC still elaborates far
    // enough to reach the parameter checks below.
    localparam int c_pre_w = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;

    localparam logic [c_pre_w-1:0] c_pre_max  = c_pre_w'(CLKS_PER_SEC - 1);
    localparam logic [c_pre_w-1:0] c_pre_zero = '0;
    localparam logic [c_pre_w-1:0] c_pre_one  = c_pre_w'(1);
    localparam logic [SEC_W-1:0]   c_sec_zero = '0;
    localparam logic [SEC_W-1:0]   c_sec_one  = SEC_W'(1);
    localparam logic [SEC_W-1:0]   c_short    = SEC_W'(SHORT_SEC);
    localparam logic [SEC_W-1:0]   c_long     = SEC_W'(LONG_SEC);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (CLKS_PER_SEC < 2) begin : g_bad_clks_per_sec
        $error("traffic_light_timer: CLKS_PER_SEC must be >= 2");
    end
    if (SHORT_SEC < 1) begin : g_bad_short_sec
        $error("traffic_light_timer: SHORT_SEC must be >= 1");
    end
    if (LONG_SEC <= SHORT_SEC) begin : g_bad_long_order
        $error("traffic_light_timer: LONG_SEC must exceed SHORT_SEC");
    end
    if ((SEC_W < 1) || (SEC_W > 30) || (LONG_SEC >= (1 << SEC_W))) begin : g_bad_long_range
        $error("traffic_light_timer: LONG_SEC must be < 2**SEC_W");
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_pre_w-1:0] pre_cnt_q, pre_cnt_d;
    logic [SEC_W-1:0]   sec_cnt_q, sec_cnt_d;
    logic               one_sec_q, one_sec_d;
    logic               five_sec_q, five_sec_d;

    logic w_frozen;
    logic w_pre_wrap;
    logic w_tick;

`ifdef TL_TIMER_HOLD_EN
    assign w_frozen = hold;
`else
    assign w_frozen = 1'b0;
`endif

    assign w_pre_wrap = (pre_cnt_q == c_pre_max);
    assign w_tick     = w_pre_wrap && !w_frozen;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        sec_cnt_d = sec_cnt_q;

        if (rst_count) begin
            // Restart dominates both a coincident tick and hold.
            pre_cnt_d = c_pre_zero;
            sec_cnt_d = c_sec_zero;
        end else if (!w_frozen) begin
            pre_cnt_d = w_pre_wrap ? c_pre_zero : (pre_cnt_q + c_pre_one);
            // Saturate at LONG_SEC so the flags stay up however late the
            // controller reacts; the prescaler keeps wrapping regardless.
            if (w_tick && (sec_cnt_q != c_long)) begin
                sec_cnt_d = sec_cnt_q + c_sec_one;
            end
        end

        // Flags follow the next count so they rise on the tick edge itself.
        // With rst_count the next count is zero, which clears both flags; while
        // frozen the next count equals the current one, so the flags hold.
        one_sec_d  = (sec_cnt_d >= c_short);
        five_sec_d = (sec_cnt_d >= c_long);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_q  <= c_pre_zero;
            sec_cnt_q  <= c_sec_zero;
            one_sec_q  <= 1'b0;
            five_sec_q <= 1'b0;
        end else begin
            pre_cnt_q  <= pre_cnt_d;
            sec_cnt_q  <= sec_cnt_d;
            one_sec_q  <= one_sec_d;
            five_sec_q <= five_sec_d;
        end
    end

    // Outputs come straight from flops: the controller derives rst_count
    // combinationally from these flags, so no path from rst_count may reach them.
    assign one_sec_timer  = one_sec_q;
    assign five_sec_timer = five_sec_q;

endmodule
`default_nettype wire
